// File: rtl/i2s_rx_capture_if.sv
// Sample-pair bus between the I2S capture block and its consumer.
interface i2s_rx_capture_if;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        sample_ready;

  modport master (output sample_l, output sample_r, output sample_valid, input sample_ready);
  modport slave  (input sample_l, input sample_r, input sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_rx_capture.sv
// I2S receiver: synchronizes BCK/WS/DATA into clk, frames 16-bit L/R words, queues pairs in a 4-deep FIFO.
// Optional statistics (frame length, short-word count) enabled by defining I2S_RX_STATS_EN.
module i2s_rx_capture (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_i2s_bck,
  input  logic             i_i2s_ws,
  input  logic             i_i2s_data,
  i2s_rx_capture_if.master o_smp,
  output logic             o_fifo_ovf,
  output logic [7:0]       o_frame_len,
  output logic [7:0]       o_short_word_cnt
);
  typedef enum logic [1:0] {S_SYNC, S_LEFT, S_RIGHT} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_bck_s;
  logic [1:0]  r_ws_s, r_dat_s;
  logic        r_prev_ws;
  logic [4:0]  r_bitcnt, w_bitcnt_nxt;
  logic [15:0] r_sh, w_sh_nxt;
  logic [15:0] r_left, w_left_nxt;
  logic        r_push, w_push_nxt;
  logic        w_rise, w_ws, w_dat, w_ws_fall, w_ws_rise;

  // BCK gets a third stage so the rise is seen on synchronized values only
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bck_s <= '0;
      r_ws_s  <= '0;
      r_dat_s <= '0;
    end else begin
      r_bck_s <= {r_bck_s[1:0], i_i2s_bck};
      r_ws_s  <= {r_ws_s[0], i_i2s_ws};
      r_dat_s <= {r_dat_s[0], i_i2s_data};
    end
  end

  assign w_rise    = r_bck_s[1] & ~r_bck_s[2];
  assign w_ws      = r_ws_s[1];
  assign w_dat     = r_dat_s[1];
  assign w_ws_fall = r_prev_ws & ~w_ws;
  assign w_ws_rise = ~r_prev_ws & w_ws;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_SYNC;
      r_prev_ws <= 1'b0;
      r_bitcnt  <= '0;
      r_sh      <= '0;
      r_left    <= '0;
      r_push    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_sh     <= w_sh_nxt;
      r_left   <= w_left_nxt;
      r_push   <= w_push_nxt;
      if (w_rise) r_prev_ws <= w_ws;
    end
  end

  // The WS-change rise carries the previous word's LSB, so it never captures
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_sh_nxt     = r_sh;
    w_left_nxt   = r_left;
    w_push_nxt   = 1'b0;
    if (w_rise) begin
      case (r_state)
        S_SYNC: begin
          if (w_ws_fall) begin
            w_state_nxt  = S_LEFT;
            w_bitcnt_nxt = '0;
          end
        end
        S_LEFT: begin
          if (w_ws_rise) begin
            w_bitcnt_nxt = '0;
            if (r_bitcnt == 5'd16) begin
              w_state_nxt = S_RIGHT;
              w_left_nxt  = r_sh;
            end else begin
              w_state_nxt = S_SYNC;
            end
          end else if (r_bitcnt != 5'd16) begin
            w_sh_nxt     = {r_sh[14:0], w_dat};
            w_bitcnt_nxt = r_bitcnt + 5'd1;
          end
        end
        S_RIGHT: begin
          if (w_ws_fall) begin
            w_state_nxt  = S_LEFT;
            w_bitcnt_nxt = '0;
          end else if (r_bitcnt != 5'd16) begin
            w_sh_nxt     = {r_sh[14:0], w_dat};
            w_bitcnt_nxt = r_bitcnt + 5'd1;
            w_push_nxt   = (r_bitcnt == 5'd15);
          end
        end
        default: w_state_nxt = S_SYNC;
      endcase
    end
  end

  // Show-ahead FIFO; r_hold keeps the last popped pair visible while empty
  logic [31:0] r_mem [4];
  logic [31:0] r_hold;
  logic [1:0]  r_wr, r_rd;
  logic [2:0]  r_cnt;
  logic        r_ovf;
  logic        w_valid, w_full, w_pop, w_wr;

  assign w_valid = (r_cnt != 3'd0);
  assign w_full  = (r_cnt == 3'd4);
  assign w_pop   = w_valid & o_smp.sample_ready;
  assign w_wr    = r_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      r_hold <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= {r_left, r_sh};
        r_wr        <= r_wr + 2'd1;
      end
      if (w_pop) begin
        r_hold <= r_mem[r_rd];
        r_rd   <= r_rd + 2'd1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (r_push & ~w_wr) r_ovf <= 1'b1;
    end
  end

  assign o_smp.sample_valid = w_valid;
  assign o_smp.sample_l     = w_valid ? r_mem[r_rd][31:16] : r_hold[31:16];
  assign o_smp.sample_r     = w_valid ? r_mem[r_rd][15:0]  : r_hold[15:0];
  assign o_fifo_ovf         = r_ovf;

`ifdef I2S_RX_STATS_EN
  logic [7:0] r_flen_cnt, r_frame_len, r_swc;
  logic       r_flen_vld, w_short;

  assign w_short = w_rise & (r_bitcnt != 5'd16) &
                   (((r_state == S_LEFT) & w_ws_rise) | ((r_state == S_RIGHT) & w_ws_fall));

  // First WS fall after reset only starts counting; later falls latch a full frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flen_cnt  <= '0;
      r_frame_len <= '0;
      r_flen_vld  <= 1'b0;
      r_swc       <= '0;
    end else begin
      if (w_rise) begin
        if (w_ws_fall) begin
          if (r_flen_vld) r_frame_len <= r_flen_cnt;
          r_flen_vld <= 1'b1;
          r_flen_cnt <= 8'd1;
        end else if (r_flen_cnt != 8'd255) begin
          r_flen_cnt <= r_flen_cnt + 8'd1;
        end
      end
      if (w_short && r_swc != 8'd255) r_swc <= r_swc + 8'd1;
    end
  end

  assign o_frame_len      = r_frame_len;
  assign o_short_word_cnt = r_swc;
`else
  assign o_frame_len      = '0;
  assign o_short_word_cnt = '0;
`endif
endmodule

// File: tb/tb_i2s_rx_capture.sv
// Directed bench for i2s_rx_capture: framing, FIFO overflow/drain, gated BCK, short words, reset mid-word.
module tb_i2s_rx_capture;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bck = 1'b0, ws = 1'b0, dat = 1'b0;
  logic       ovf;
  logic [7:0] frame_len, swc;

`ifdef I2S_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  i2s_rx_capture_if bus();

  i2s_rx_capture dut (
    .clk              (clk),
    .reset            (reset),
    .i_i2s_bck        (bck),
    .i_i2s_ws         (ws),
    .i_i2s_data       (dat),
    .o_smp            (bus.master),
    .o_fifo_ovf       (ovf),
    .o_frame_len      (frame_len),
    .o_short_word_cnt (swc)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] q[$];
  int          vcyc = 0;

  // Records every popped pair and counts valid cycles
  always @(negedge clk) begin
    if (!reset && bus.sample_valid) begin
      vcyc++;
      if (bus.sample_ready) q.push_back({bus.sample_l, bus.sample_r});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic w, input logic d);
    bck = 1'b0; ws = w; dat = d;
    #30;
    bck = 1'b1;
    #30;
  endtask

  // First rise carries the WS change, then nbits MSB-first, then zero padding
  task automatic half(input logic w, input logic [15:0] word, input int nbits, input int nrises, input int gap);
    for (int k = 0; k < nrises; k++)
      bit_out(w, (k >= 1 && k <= nbits) ? word[4'(16 - k)] : 1'b0);
    if (gap > 0) begin
      bck = 1'b0;
      #(gap * 10);
    end
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int gap);
    half(1'b0, l, 16, 32, gap);
    half(1'b1, r, 16, 32, gap);
  endtask

  initial begin
    int base, v0;
    logic [15:0] w7;
    bus.sample_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.sample_valid), 32'd0);
    chk("rst_l", 32'(bus.sample_l), 32'd0);
    chk("rst_r", 32'(bus.sample_r), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_frame_len", 32'(frame_len), 32'd0);
    chk("rst_swc", 32'(swc), 32'd0);
    reset = 1'b0;
    bus.sample_ready = 1'b1;

    // First frame is only used to find the WS 1->0 edge
    base = q.size(); v0 = vcyc;
    repeat (3) frame(16'hA55A, 16'h0F0F, 0);
    #200;
    chk("basic_npairs", 32'(q.size() - base), 32'd2);
    chk("basic_pair0", q[base], 32'hA55A0F0F);
    chk("basic_pair1", q[base + 1], 32'hA55A0F0F);
    chk("basic_valid_cycles", 32'(vcyc - v0), 32'd2);
    chk("basic_ovf", 32'(ovf), 32'd0);

    // Back-pressure: 5 pairs into a 4-deep FIFO
    bus.sample_ready = 1'b0;
    base = q.size();
    for (int i = 0; i < 5; i++) frame(16'(16'h1000 + i), 16'(16'h2000 + i), 0);
    #200;
    chk("full_valid", 32'(bus.sample_valid), 32'd1);
    chk("full_ovf", 32'(ovf), 32'd1);
    chk("full_nopop", 32'(q.size() - base), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("drain_l%0d", i), 32'(bus.sample_l), 32'(16'h1000 + i));
      chk($sformatf("drain_r%0d", i), 32'(bus.sample_r), 32'(16'h2000 + i));
      bus.sample_ready = 1'b1;
      @(posedge clk); #1;
      bus.sample_ready = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_valid", 32'(bus.sample_valid), 32'd0);
    chk("drain_hold_l", 32'(bus.sample_l), 32'h1003);
    chk("drain_hold_r", 32'(bus.sample_r), 32'h2003);
    chk("drain_npops", 32'(q.size() - base), 32'd4);

    // Gated BCK: 20-clk pauses between half-frame bursts
    bus.sample_ready = 1'b1;
    base = q.size(); v0 = vcyc;
    repeat (2) frame(16'hBEEF, 16'h1234, 20);
    #200;
    chk("gated_npairs", 32'(q.size() - base), 32'd2);
    chk("gated_pair0", q[base], 32'hBEEF1234);
    chk("gated_pair1", q[base + 1], 32'hBEEF1234);
    chk("gated_valid_cycles", 32'(vcyc - v0), 32'd2);

    // Right word cut after 10 bits
    base = q.size();
    half(1'b0, 16'hC3C3, 16, 32, 0);
    half(1'b1, 16'hABCD, 10, 11, 0);
    frame(16'h5A5A, 16'hA5A5, 0);
    #200;
    chk("short_npairs", 32'(q.size() - base), 32'd1);
    chk("short_pair", q[base], 32'h5A5AA5A5);
    chk("short_swc", 32'(swc), STATS ? 32'd1 : 32'd0);

    // 83-rise frames (41 left + 42 right)
    base = q.size();
    half(1'b0, 16'h1111, 16, 41, 0);
    half(1'b1, 16'h2222, 16, 42, 0);
    half(1'b0, 16'h3333, 16, 41, 0);
    half(1'b1, 16'h4444, 16, 42, 0);
    #200;
    chk("len83_npairs", 32'(q.size() - base), 32'd2);
    chk("len83_pair0", q[base], 32'h11112222);
    chk("len83_pair1", q[base + 1], 32'h33334444);
    chk("len83_frame_len", 32'(frame_len), STATS ? 32'd83 : 32'd0);

    // Reset pulse while the 8th left bit is on the wire
    base = q.size();
    w7 = 16'h7E81;
    for (int k = 0; k < 32; k++) begin
      bck = 1'b0; ws = 1'b0;
      dat = (k >= 1 && k <= 16) ? w7[4'(16 - k)] : 1'b0;
      if (k == 8) begin
        reset = 1'b1;
        #20;
        reset = 1'b0;
      end
      #30;
      bck = 1'b1;
      #30;
    end
    half(1'b1, 16'hABAB, 16, 32, 0);
    #200;
    chk("rstmid_valid", 32'(bus.sample_valid), 32'd0);
    chk("rstmid_ovf", 32'(ovf), 32'd0);
    chk("rstmid_swc", 32'(swc), 32'd0);
    frame(16'h7E81, 16'h18E7, 0);
    #200;
    chk("rstmid_npairs", 32'(q.size() - base), 32'd1);
    chk("rstmid_pair", q[base], 32'h7E8118E7);
    chk("rstmid_frame_len", 32'(frame_len), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
